// File: rtl/cardinal_nic.sv
// PE-side network interface: one-deep outbound and inbound packet buffers behind
// a four-entry register file, with outbound injection gated by the router phase.
module cardinal_nic #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);

  localparam logic [1:0] A_IN_BUF  = 2'b00;
  localparam logic [1:0] A_IN_STAT = 2'b01;
  localparam logic [1:0] A_OUT_BUF = 2'b10;
  localparam logic [1:0] A_OUT_STAT= 2'b11;

  logic [DATA_W-1:0] in_buf, out_buf;
  logic              in_full, out_full;
  logic              rd, wr, capture, drain, rd_clr, wr_out;

  assign rd      = nicEn & ~nicWrEn;
  assign wr      = nicEn &  nicWrEn;
  assign net_ri  = ~in_full;
  assign capture = net_si & net_ri;
  // Even phase exposes VC1, odd phase exposes VC0.
  assign net_so  = out_full & (net_polarity != out_buf[DATA_W-1]);
  assign net_do  = net_so ? out_buf : '0;
  assign drain   = net_so & net_ro;
  assign rd_clr  = rd & (addr == A_IN_BUF) & in_full;
  // A write into a full buffer is dropped, even if the same cycle drains it.
  assign wr_out  = wr & (addr == A_OUT_BUF) & ~out_full;

  always_comb begin
    d_out = '0;
    if (rd) begin
      unique case (addr)
        A_IN_BUF:   d_out = in_buf;
        A_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full};
        A_OUT_BUF:  d_out = out_buf;
        A_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
        default:    d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf   <= '0;
      in_full  <= 1'b0;
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      // capture needs in_full=0 and rd_clr needs in_full=1, so they never overlap
      if (capture) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end else if (rd_clr) begin
        in_full <= 1'b0;
      end
      if (drain) begin
        out_full <= 1'b0;
      end else if (wr_out) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic: queues hold the packets expected out of each
// buffer; the outbound queue is drained by the per-cycle monitor in tick().
module tb_cardinal_nic;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in, d_out, net_di, net_do;
  logic              nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int checks = 0;
  int errors = 0;
  int sent   = 0;
  int so_cnt = 0;
  logic [DATA_W-1:0] out_q[$];
  logic [DATA_W-1:0] in_q[$];

  cardinal_nic #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample the settled cycle, score any outbound transfer, then cross the edge.
  task automatic tick();
    logic vc_inv;
    logic [DATA_W-1:0] exp;
    #1;
    if (net_so) begin
      so_cnt++;
      vc_inv = ~net_do[DATA_W-1];
      chk("so_phase", {{(DATA_W-1){1'b0}}, net_polarity}, {{(DATA_W-1){1'b0}}, vc_inv});
      if (net_ro) begin
        sent++;
        if (out_q.size() == 0) chk("unexpected_send", net_do, '0);
        else begin
          exp = out_q.pop_front();
          chk("net_do", net_do, exp);
        end
      end
    end
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
    #1 chk("d_out_on_write", d_out, '0);
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic pe_read(input string tag, input logic [1:0] a, input logic [DATA_W-1:0] exp);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    #1 chk(tag, d_out, exp);
    tick();
    nicEn = 1'b0;
  endtask

  task automatic pe_read_in();
    logic [DATA_W-1:0] exp;
    if (in_q.size() == 0) chk("in_q_size", DATA_W'(in_q.size()), 1);
    else begin
      exp = in_q.pop_front();
      pe_read("in_buf", 2'b00, exp);
    end
  endtask

  // Advance until net_so is up in the current cycle (bounded).
  task automatic wait_so(input string tag);
    bit hit = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (net_so) begin hit = 1; break; end
      tick();
    end
    chk(tag, {{(DATA_W-1){1'b0}}, hit}, 1);
  endtask

  task automatic flush_out(input string tag, input int n);
    for (int i = 0; i < n && out_q.size() != 0; i++) tick();
    chk(tag, DATA_W'(out_q.size()), 0);
  endtask

  initial begin
    int s0;
    reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    #2;
    chk("rst_net_ri", {63'b0, net_ri}, 1);
    chk("rst_net_so", {63'b0, net_so}, 0);
    chk("rst_net_do", net_do, '0);
    chk("rst_d_out",  d_out, '0);
    #1 reset = 1'b1;
    tick(); tick();

    // VC0 packet: only presented on odd phase
    net_ro = 1'b1;
    pe_write(2'b10, 64'h0000_0000_0000_00AA); out_q.push_back(64'h0000_0000_0000_00AA);
    flush_out("vc0_sent", 3);
    pe_read("out_stat_vc0", 2'b11, 0);

    // VC1 packet with backpressure: presented every other cycle
    net_ro = 1'b0;
    pe_write(2'b10, 64'h8000_0000_0000_0055); out_q.push_back(64'h8000_0000_0000_0055);
    s0 = so_cnt;
    repeat (4) tick();
    chk("bp_pulses", DATA_W'(so_cnt - s0), 2);
    chk("bp_held", DATA_W'(out_q.size()), 1);
    net_ro = 1'b1;
    flush_out("vc1_sent", 2);

    // second write to a full buffer is dropped
    net_ro = 1'b0;
    pe_write(2'b10, 64'h0000_0000_0000_0A0A); out_q.push_back(64'h0000_0000_0000_0A0A);
    pe_write(2'b10, 64'h0000_0000_0000_0B0B);
    pe_read("out_buf_keeps_a", 2'b10, 64'h0000_0000_0000_0A0A);
    pe_read("out_stat_full", 2'b11, 1);
    net_ro = 1'b1;
    s0 = sent;
    repeat (4) tick();
    chk("a_sent_once", DATA_W'(sent - s0), 1);
    pe_read("out_stat_drained", 2'b11, 0);

    // write in the very cycle the buffer drains is also dropped
    pe_write(2'b10, 64'h0000_0000_0000_0C0C); out_q.push_back(64'h0000_0000_0000_0C0C);
    wait_so("c_presented");
    pe_write(2'b10, 64'h0000_0000_0000_0D0D);
    s0 = sent;
    repeat (3) tick();
    chk("d_not_sent", DATA_W'(sent - s0), 0);
    pe_read("out_stat_after_drop", 2'b11, 0);

    // inbound flow control
    net_si = 1'b1; net_di = 64'h1234;
    #1 chk("ri_empty", {63'b0, net_ri}, 1);
    tick(); in_q.push_back(64'h1234);
    net_di = 64'h5678;
    #1 chk("ri_full", {63'b0, net_ri}, 0);
    tick();
    pe_read("in_stat_full", 2'b01, 1);
    pe_read_in();
    #1 chk("ri_after_read", {63'b0, net_ri}, 1);
    tick(); in_q.push_back(64'h5678);
    net_si = 1'b0;
    pe_read("in_stat_5678", 2'b01, 1);
    pe_read_in();
    pe_read("in_stat_empty", 2'b01, 0);

    // concurrent inbound capture and outbound drain
    pe_write(2'b10, 64'h8000_0000_0000_0E0E); out_q.push_back(64'h8000_0000_0000_0E0E);
    wait_so("e_presented");
    net_si = 1'b1; net_di = 64'h9ABC;
    tick(); in_q.push_back(64'h9ABC);
    net_si = 1'b0;
    chk("conc_out_q", DATA_W'(out_q.size()), 0);
    pe_read("conc_in_stat", 2'b01, 1);
    pe_read("conc_out_stat", 2'b11, 0);
    pe_read_in();

    // asynchronous reset with both buffers full
    net_ro = 1'b0;
    pe_write(2'b10, 64'h0000_0000_0000_0F0F);
    net_si = 1'b1; net_di = 64'h1111;
    tick();
    net_si = 1'b0;
    pe_read("pre_rst_in", 2'b01, 1);
    pe_read("pre_rst_out", 2'b11, 1);
    #2 reset = 1'b0;
    addr = 2'b01; nicEn = 1'b1; nicWrEn = 1'b0;
    #1;
    chk("mid_rst_net_ri", {63'b0, net_ri}, 1);
    chk("mid_rst_net_so", {63'b0, net_so}, 0);
    chk("mid_rst_in_stat", d_out, '0);
    addr = 2'b11;
    #1 chk("mid_rst_out_stat", d_out, '0);
    addr = 2'b00;
    #1 chk("mid_rst_in_buf", d_out, '0);
    nicEn = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    net_ro = 1'b1;
    s0 = sent;
    repeat (3) tick();
    chk("post_rst_no_send", DATA_W'(sent - s0), 0);
    pe_read("post_rst_out_stat", 2'b11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller bridging one processing element (PE) to the PE port of the two-VC phase-multiplexed router. The PE writes and reads a small memory-mapped register file. The NIC holds one outbound packet and one inbound packet, and handshakes with the router over ready/send signals. Outbound injection is gated by the router's polarity output, so each packet is presented only in the phase where its virtual channel is exposed externally.

## Interface
Parameters:
- DATA_W, 64, packet/register width; bit DATA_W-1 is the VC bit.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  2  register select: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status
- d_in  in  DATA_W  PE write data
- d_out  out  DATA_W  PE read data (combinational)
- nicEn  in  1  register access enable
- nicWrEn  in  1  1 = write, 0 = read (valid with nicEn)
- net_si  in  1  router has a packet for the PE (router pe_so)
- net_ri  out  1  NIC can accept an inbound packet (router pe_ro)
- net_di  in  DATA_W  inbound packet (router pe_do)
- net_so  out  1  NIC presents an outbound packet (router pe_si)
- net_ro  in  1  router can accept the outbound packet (router pe_ri)
- net_do  out  DATA_W  outbound packet (router pe_di)
- net_polarity  in  1  router polarity; 0 = even cycle, 1 = odd cycle

## Operation
- State: in_buf[DATA_W], in_full, out_buf[DATA_W], out_full.
- Reset (reset low, asynchronous): in_full=0, out_full=0, in_buf=0, out_buf=0.
- Outputs during reset: net_ri=1, net_so=0, net_do=0, d_out=0.
- Register read (nicEn=1, nicWrEn=0), d_out:
  - addr 00 → in_buf
  - addr 01 → {63'b0, in_full}
  - addr 10 → out_buf
  - addr 11 → {63'b0, out_full}
- d_out=0 whenever nicEn=0 or nicWrEn=1.
- Read of addr 00 with in_full=1 clears in_full at the next edge. Reading addr 00 when empty has no side effect.
- Register write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0 → out_buf←d_in, out_full←1.
  - addr 10 with out_full=1 is dropped. This holds even if the same cycle drains the buffer; no overwrite.
  - Writes to 00/01/11 are ignored.
- Inbound path:
  - net_ri = ~in_full.
  - On net_si & net_ri: in_buf←net_di, in_full←1.
  - net_si while full is not accepted. The router holds the packet.
- Outbound path:
  - net_so = out_full & (net_polarity != out_buf[DATA_W-1]).
  - Even cycles expose VC1 and odd cycles expose VC0.
  - net_do = out_buf when net_so=1, else 0.
  - On net_so & net_ro: out_full←0 at the edge.
  - net_so with net_ro=0: hold, and retry at the next matching phase.
- Simultaneous events:
  - PE read-clear of in_full and a new arrival cannot coincide, because net_ri=0 while full.
  - Outbound drain and PE write in the same cycle: drain wins and the write is dropped.
  - Inbound capture and outbound drain are independent and may occur in the same cycle.
- Reset asserted mid-handshake discards both buffers immediately. No partial packet survives.

## Timing
- Write→inject:
  - PE write at edge N sets out_full.
  - net_so is asserted in cycle N+1 if the phase matches, else N+2.
  - Worst case is 2 cycles to first presentation.
- Inject→free: out_full clears at the edge where net_so & net_ro. A new PE write is accepted the following cycle.
- Arrival→visible: capture at edge M. in-status reads 1 and net_ri=0 from cycle M+1.
- Read-clear: read of 00 at edge K. net_ri=1 from cycle K+1, so the next capture is possible at edge K+1.
- Throughput: at most one outbound packet per 2 cycles per VC bit value, and one inbound packet per PE read.
- All outputs combinational from registered state plus addr/nicEn/nicWrEn/net_polarity. There are no internal combinational paths from net_si to net_so.

## Test plan
- Reset:
  - Drive reset low mid-operation with both buffers full.
  - Required immediately: net_ri=1, net_so=0, status reads 0.
- Even-VC inject:
  - Write 64'h0000_0000_0000_00AA (VC0) with net_ro=1.
  - Required: net_so=1 only in a cycle with net_polarity=1, net_do=…AA; out-status 0 afterwards.
- Odd-VC inject with backpressure:
  - Write 64'h8000_0000_0000_0055, hold net_ro=0 for 4 cycles.
  - Required: net_so pulses only on polarity=0 cycles; the packet is sent on the first polarity=0 cycle after net_ro=1.
- Full-buffer write drop:
  - Write A then B while net_ro=0.
  - Required: out_buf=A; B is lost; A is sent once.
- Inbound flow control:
  - Drive net_si=1 with 64'h1234, then net_si=1 with 64'h5678 without a PE read.
  - Required: net_ri=0 after the first capture; in-buf reads 1234; after reading 00, net_ri=1 and 5678 is captured next edge.
- Concurrent traffic:
  - Inbound arrival and outbound drain in the same cycle.
  - Required: both complete; status reads in=1, out=0.
